// File: rtl/ref_seq_pkg.sv
// Shared types and constants for the servo reference sequencer.
package ref_seq_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2
    } seq_state_e;

    localparam int SEL_W         = 4;
    localparam int CANT_BITS_DEF = 16;

endpackage

// File: rtl/sel_debounce.sv
// Debounces the setpoint selection: a new value must stay stable for DEB_CYCLES
// enabled cycles before it is accepted, which emits a one-cycle new_sel pulse.
module sel_debounce
    import ref_seq_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [SEL_W-1:0] stable_o,
    output logic             new_sel_o
);

    localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CYCLES - 1);

    logic [SEL_W-1:0] cand_q, cand_d;
    logic [SEL_W-1:0] stable_q, stable_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             new_sel;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        // Once cand is promoted it equals stable, so the pulse lasts one cycle.
        new_sel  = en_i && (cnt_q == CNT_MAX) && (cand_q != stable_q);
        if (en_i) begin
            if (sel_i != cand_q) begin
                cand_d = sel_i;
                cnt_d  = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (new_sel) begin
            stable_d = cand_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o  = stable_q;
    assign new_sel_o = new_sel;

endmodule

// File: rtl/ref_sequencer.sv
// Servo reference sequencer: fetches the accepted setpoint constant and slews the
// reference toward it by at most STEP per sample request from the control loop.
module ref_sequencer
    import ref_seq_pkg::*;
#(
    parameter int cant_bits  = CANT_BITS_DEF,
    parameter int STEP       = 64,
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic                        CLK_G,
    input  logic                        reset_G,
    input  logic                        En,
    input  logic [SEL_W-1:0]            sel,
    input  logic signed [cant_bits-1:0] const_in,
    input  logic                        sample_req,
    output logic [SEL_W-1:0]            const_addr,
    output logic signed [cant_bits-1:0] ref_out,
    output logic                        ref_valid,
    output logic                        busy,
    output logic [SEL_W-1:0]            disp_st
);

    logic             new_sel;
    logic [SEL_W-1:0] stable;

    sel_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_sel_debounce (
        .clk_i     (CLK_G),
        .rst_ni    (reset_G),
        .en_i      (En),
        .sel_i     (sel),
        .stable_o  (stable),
        .new_sel_o (new_sel)
    );

    // Difference is taken one bit wider so full-scale swings cannot wrap; the
    // final partial step lands exactly on the target, never past it.
    function automatic logic signed [cant_bits-1:0] slew_next(
        input logic signed [cant_bits-1:0] cur,
        input logic signed [cant_bits-1:0] tgt
    );
        logic signed [cant_bits:0] diff;
        logic signed [cant_bits:0] mag;
        logic signed [cant_bits:0] step_x;
        step_x = (cant_bits+1)'(STEP);
        diff   = {tgt[cant_bits-1], tgt} - {cur[cant_bits-1], cur};
        mag    = diff[cant_bits] ? -diff : diff;
        if (mag <= step_x)        return tgt;
        else if (!diff[cant_bits]) return cur + cant_bits'(STEP);
        else                       return cur - cant_bits'(STEP);
    endfunction

    seq_state_e                  state_q, state_d;
    logic signed [cant_bits-1:0] target_q, target_d;
    logic signed [cant_bits-1:0] ref_q, ref_d;
    logic signed [cant_bits-1:0] stepped;
    logic                        ref_valid_q;
    logic                        busy_q;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        ref_d    = ref_q;
        stepped  = slew_next(ref_q, target_q);
        case (state_q)
            FETCH: begin
                target_d = const_in;
                state_d  = (const_in == ref_q) ? HOLD : RAMP;
            end
            RAMP: begin
                if (sample_req) begin
                    ref_d = stepped;
                    if (stepped == target_q) state_d = HOLD;
                end
            end
            HOLD: ;
            default: state_d = FETCH;
        endcase
        // A newly accepted selection wins over the step's next state; the step
        // itself still applies and the ramp retargets from wherever it is.
        if (new_sel) state_d = FETCH;
    end

    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            state_q     <= FETCH;
            target_q    <= '0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            ref_q       <= ref_d;
            ref_valid_q <= sample_req;
            busy_q      <= (state_d != HOLD);
        end
    end

    assign const_addr = stable;
    assign disp_st    = stable;
    assign ref_out    = ref_q;
    assign ref_valid  = ref_valid_q;
    assign busy       = busy_q;

endmodule
